// File: rtl/islemci_test_uretici.sv
// Processor-side traffic generator: writes TEST_LEN pattern words, then reads them back one by one and compares.
// Optional watchdog is built in when TEST_ZAMAN_ASIMI_EN is defined.
module islemci_test_uretici #(
  parameter int unsigned TEST_LEN    = 16384,
  parameter logic [31:0] VERI_TABANI = 32'hABCD_0000,
  parameter int unsigned ZAMAN_ASIMI = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        baslat_i,
  output logic [31:0] islemci_istek_adres_o,
  output logic [31:0] islemci_istek_veri_o,
  output logic        islemci_istek_gecerli_o,
  output logic        islemci_istek_yaz_o,
  input  logic        islemci_istek_hazir_i,
  input  logic [31:0] islemci_cevap_veri_i,
  input  logic        islemci_cevap_gecerli_i,
  output logic        islemci_cevap_hazir_o,
  output logic        bitti_o,
  output logic        basarili_o,
  output logic [15:0] hata_sayisi_o,
  output logic [31:0] ilk_hata_adres_o,
  output logic        zaman_asimi_o
);

  typedef enum logic [2:0] {BOSTA, YAZ, OKU_ISTEK, OKU_CEVAP, BITTI} durum_t;

  localparam logic [31:0] SON = 32'(TEST_LEN - 1);

  function automatic logic [31:0] desen(input logic [31:0] idx);
    return (VERI_TABANI + idx) & 32'hFFFF_FFFC;
  endfunction

  durum_t      r_durum;
  logic [31:0] r_i;
  logic [31:0] r_adres;
  logic [31:0] r_veri;
  logic        r_gecerli;
  logic        r_yaz;
  logic        r_cevap_hazir;
  logic        r_bitti;
  logic        r_basarili;
  logic [15:0] r_hata;
  logic [31:0] r_ilk_hata;

  logic        w_istek_kabul;
  logic        w_cevap_kabul;
  logic        w_veri_hatali;
  logic [15:0] w_hata_sonraki;
  logic        w_zaman_doldu;

  assign w_istek_kabul  = r_gecerli & islemci_istek_hazir_i;
  assign w_cevap_kabul  = islemci_cevap_gecerli_i & r_cevap_hazir;
  assign w_veri_hatali  = (islemci_cevap_veri_i != desen(r_i));
  assign w_hata_sonraki = (w_veri_hatali && (r_hata != '1)) ? r_hata + 16'd1 : r_hata;

`ifdef TEST_ZAMAN_ASIMI_EN
  logic [31:0] r_sayac;
  logic        r_zaman_asimi;
  logic        w_aktif;
  logic        w_ilerleme;

  assign w_aktif       = (r_durum == YAZ) || (r_durum == OKU_ISTEK) || (r_durum == OKU_CEVAP);
  assign w_ilerleme    = w_istek_kabul | w_cevap_kabul;
  assign w_zaman_doldu = w_aktif && !w_ilerleme && (r_sayac == 32'(ZAMAN_ASIMI - 1));

  // Every state change in an active state coincides with an acceptance, so one reset term covers both.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_aktif || w_ilerleme) begin
      r_sayac <= '0;
    end else begin
      r_sayac <= r_sayac + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zaman_asimi <= 1'b0;
    end else if (w_zaman_doldu) begin
      r_zaman_asimi <= 1'b1;
    end else if (((r_durum == BOSTA) || (r_durum == BITTI)) && baslat_i) begin
      r_zaman_asimi <= 1'b0;
    end
  end

  assign zaman_asimi_o = r_zaman_asimi;
`else
  assign w_zaman_doldu = 1'b0;
  assign zaman_asimi_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum       <= BOSTA;
      r_i           <= '0;
      r_adres       <= '0;
      r_veri        <= '0;
      r_gecerli     <= 1'b0;
      r_yaz         <= 1'b0;
      r_cevap_hazir <= 1'b0;
      r_bitti       <= 1'b0;
      r_basarili    <= 1'b0;
      r_hata        <= '0;
      r_ilk_hata    <= '0;
    end else if (w_zaman_doldu) begin
      r_durum       <= BITTI;
      r_gecerli     <= 1'b0;
      r_cevap_hazir <= 1'b0;
      r_bitti       <= 1'b1;
      r_basarili    <= 1'b0;
    end else begin
      case (r_durum)
        BOSTA, BITTI: begin
          if (baslat_i) begin
            r_i        <= '0;
            r_hata     <= '0;
            r_ilk_hata <= '0;
            r_bitti    <= 1'b0;
            r_basarili <= 1'b0;
            if (TEST_LEN == 0) begin
              r_durum    <= BITTI;
              r_bitti    <= 1'b1;
              r_basarili <= 1'b1;
            end else begin
              r_durum   <= YAZ;
              r_gecerli <= 1'b1;
              r_yaz     <= 1'b1;
              r_adres   <= '0;
              r_veri    <= desen('0);
            end
          end
        end
        YAZ: begin
          if (w_istek_kabul) begin
            if (r_i == SON) begin
              // Last write accepted: the first read is presented immediately, request stays valid.
              r_i     <= '0;
              r_durum <= OKU_ISTEK;
              r_yaz   <= 1'b0;
              r_adres <= '0;
              r_veri  <= '0;
            end else begin
              r_i     <= r_i + 32'd1;
              r_adres <= r_i + 32'd1;
              r_veri  <= desen(r_i + 32'd1);
            end
          end
        end
        OKU_ISTEK: begin
          if (w_istek_kabul) begin
            r_gecerli     <= 1'b0;
            r_cevap_hazir <= 1'b1;
            r_durum       <= OKU_CEVAP;
          end
        end
        OKU_CEVAP: begin
          if (w_cevap_kabul) begin
            r_cevap_hazir <= 1'b0;
            r_hata        <= w_hata_sonraki;
            if (w_veri_hatali && (r_hata == '0)) begin
              r_ilk_hata <= r_i;
            end
            if (r_i == SON) begin
              r_durum    <= BITTI;
              r_bitti    <= 1'b1;
              r_basarili <= (w_hata_sonraki == '0);
            end else begin
              r_i       <= r_i + 32'd1;
              r_adres   <= r_i + 32'd1;
              r_gecerli <= 1'b1;
              r_durum   <= OKU_ISTEK;
            end
          end
        end
        default: begin
          r_durum <= BOSTA;
        end
      endcase
    end
  end

  assign islemci_istek_adres_o   = r_adres;
  assign islemci_istek_veri_o    = r_veri;
  assign islemci_istek_gecerli_o = r_gecerli;
  assign islemci_istek_yaz_o     = r_yaz;
  assign islemci_cevap_hazir_o   = r_cevap_hazir;
  assign bitti_o                 = r_bitti;
  assign basarili_o              = r_basarili;
  assign hata_sayisi_o           = r_hata;
  assign ilk_hata_adres_o        = r_ilk_hata;

endmodule

// File: tb/tb_islemci_test_uretici.sv
// Bench for islemci_test_uretici: memory-like responder with optional random stalls and planted corruptions.
`timescale 1ns/1ps
module tb_islemci_test_uretici;

  localparam int unsigned N    = 16;
  localparam logic [31:0] BASE = 32'hFFFF_FFF5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baslat = 1'b0;
  logic        baslat0 = 1'b0;
  logic        hazir = 1'b0;
  logic        cv_gecerli = 1'b0;
  logic [31:0] cv_veri = '0;

  logic [31:0] adres, veri, ilk, adres0, veri0, ilk0;
  logic        gecerli, yaz, cevap_hazir, bitti, basarili, za;
  logic        gecerli0, yaz0, cevap_hazir0, bitti0, basarili0, za0;
  logic [15:0] hata, hata0;

  islemci_test_uretici #(.TEST_LEN(N), .VERI_TABANI(BASE), .ZAMAN_ASIMI(32)) dut (
    .clk_i(clk), .rst_i(rst), .baslat_i(baslat),
    .islemci_istek_adres_o(adres), .islemci_istek_veri_o(veri),
    .islemci_istek_gecerli_o(gecerli), .islemci_istek_yaz_o(yaz),
    .islemci_istek_hazir_i(hazir),
    .islemci_cevap_veri_i(cv_veri), .islemci_cevap_gecerli_i(cv_gecerli),
    .islemci_cevap_hazir_o(cevap_hazir),
    .bitti_o(bitti), .basarili_o(basarili), .hata_sayisi_o(hata),
    .ilk_hata_adres_o(ilk), .zaman_asimi_o(za)
  );

  islemci_test_uretici #(.TEST_LEN(0), .VERI_TABANI(BASE), .ZAMAN_ASIMI(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .baslat_i(baslat0),
    .islemci_istek_adres_o(adres0), .islemci_istek_veri_o(veri0),
    .islemci_istek_gecerli_o(gecerli0), .islemci_istek_yaz_o(yaz0),
    .islemci_istek_hazir_i(hazir),
    .islemci_cevap_veri_i(cv_veri), .islemci_cevap_gecerli_i(cv_gecerli),
    .islemci_cevap_hazir_o(cevap_hazir0),
    .bitti_o(bitti0), .basarili_o(basarili0), .hata_sayisi_o(hata0),
    .ilk_hata_adres_o(ilk0), .zaman_asimi_o(za0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state
  int          wr_n = 0, rd_n = 0, outst = 0, cevap_cyc = 0, cyc = 0, wr_first = 0, wr_last = 0;
  bit          hold = 0, rnd = 0, no_resp = 0;
  logic [31:0] h_adres, h_veri;
  logic        h_yaz;
  logic [31:0] mem [N];
  logic [15:0] mask = '0;

  function automatic logic [31:0] desen(input logic [31:0] i);
    return (BASE + i) & ~32'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : responder
    bit          pend;
    bit          racc;
    int          dly;
    logic [31:0] paddr;
    pend = 0; dly = 0; paddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      racc = 0;
      if (rst) begin
        pend = 0; hold = 0; wr_n = 0; rd_n = 0; outst = 0;
      end else begin
        chk("len0_gecerli", 32'(gecerli0), 32'd0);
        chk("len0_cevap_hazir", 32'(cevap_hazir0), 32'd0);
        chk("req_with_cevap_hazir", 32'(gecerli & cevap_hazir), 32'd0);
        if (hold) begin
          chk("hold_adres", adres, h_adres);
          chk("hold_veri", veri, h_veri);
          chk("hold_ctl", {30'd0, gecerli, yaz}, {30'd0, 1'b1, h_yaz});
        end
        if (cevap_hazir) cevap_cyc++;
        if (gecerli && hazir) begin
          if (yaz) begin
            chk("wr_adres", adres, 32'(wr_n));
            chk("wr_veri", veri, desen(32'(wr_n)));
            mem[adres[3:0]] = veri;
            if (wr_n == 0) wr_first = cyc;
            wr_last = cyc;
            wr_n++;
          end else begin
            chk("rd_adres", adres, 32'(rd_n));
            chk("rd_veri_zero", veri, 32'd0);
            chk("rd_outstanding", 32'(outst), 32'd0);
            outst++;
            rd_n++;
            pend  = 1;
            paddr = adres;
            dly   = rnd ? int'($urandom_range(0, 7)) : 0;
          end
          hold = 0;
        end else if (gecerli) begin
          hold = 1; h_adres = adres; h_veri = veri; h_yaz = yaz;
        end else begin
          hold = 0;
        end
        if (cv_gecerli && cevap_hazir) begin
          racc = 1; pend = 0; outst--;
        end
      end
      @(posedge clk);
      #1;
      hazir = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rst || racc) cv_gecerli = 1'b0;
      if (!rst && pend && !cv_gecerli && !no_resp) begin
        if (dly == 0) begin
          cv_gecerli = 1'b1;
          cv_veri    = mem[paddr[3:0]] ^ {31'd0, mask[paddr[3:0]]};
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic run_pass(input logic [15:0] m, input bit r, input bit mid_baslat);
    int          exp_err;
    int          exp_first;
    bit          found;
    int          k;
    mask = m; rnd = r; wr_n = 0; rd_n = 0; cevap_cyc = 0;
    baslat = 1'b1;
    step();
    baslat = 1'b0;
    for (k = 0; k < 2000 && !bitti; k++) begin
      baslat = (mid_baslat && k == 40);
      step();
    end
    baslat = 1'b0;
    chk("wait_bitti", 32'(bitti), 32'd1);
    exp_err = 0; exp_first = 0; found = 0;
    for (int a = 0; a < int'(N); a++) begin
      if (m[a]) begin
        exp_err++;
        if (!found) begin exp_first = a; found = 1; end
      end
    end
    chk("basarili", 32'(basarili), 32'(exp_err == 0));
    chk("hata_sayisi", 32'(hata), 32'(exp_err));
    chk("ilk_hata_adres", ilk, 32'(exp_first));
    chk("zaman_asimi", 32'(za), 32'd0);
    chk("write_count", 32'(wr_n), 32'(N));
    chk("read_count", 32'(rd_n), 32'(N));
    chk("idle_gecerli", 32'(gecerli), 32'd0);
    chk("idle_cevap_hazir", 32'(cevap_hazir), 32'd0);
    if (!r) chk("write_burst_span", 32'(wr_last - wr_first), 32'(N - 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gecerli"}, 32'(gecerli), 32'd0);
    chk({tag, "_yaz"}, 32'(yaz), 32'd0);
    chk({tag, "_adres"}, adres, 32'd0);
    chk({tag, "_veri"}, veri, 32'd0);
    chk({tag, "_cevap_hazir"}, 32'(cevap_hazir), 32'd0);
    chk({tag, "_flags"}, {29'd0, bitti, basarili, za}, 32'd0);
    chk({tag, "_hata"}, 32'(hata), 32'd0);
    chk({tag, "_ilk"}, ilk, 32'd0);
  endtask

  initial begin : stimulus
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero("reset");
    end
    chk("reset_len0_bitti", 32'(bitti0), 32'd0);
    // Release reset with baslat already high: the release cycle must not carry a request.
    rst = 1'b0;
    baslat = 1'b1;
    @(negedge clk);
    chk("no_req_after_release", 32'(gecerli), 32'd0);
    step();
    baslat = 1'b0;
    chk("start_gecerli", 32'(gecerli), 32'd1);
    for (k = 0; k < 500 && !bitti; k++) step();
    chk("first_pass_bitti", 32'(bitti), 32'd1);
    chk("first_pass_basarili", 32'(basarili), 32'd1);

    run_pass(16'h0000, 1'b0, 1'b0);
    run_pass(16'h0220, 1'b0, 1'b0);
    run_pass(16'h0000, 1'b1, 1'b1);
    for (int t = 0; t < 3; t++) run_pass(16'($urandom()), 1'b1, 1'b0);
    run_pass(16'hFFFF, 1'b1, 1'b0);

    // Reset while waiting for the response to address 7
    mask = '0; rnd = 0; wr_n = 0; rd_n = 0;
    baslat = 1'b1;
    step();
    baslat = 1'b0;
    for (k = 0; k < 300 && !(cevap_hazir && rd_n == 8); k++) step();
    chk("rst_point_reached", 32'(cevap_hazir && rd_n == 8), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    step();
    chk("after_rst_idle", 32'(gecerli), 32'd0);
    run_pass(16'h0000, 1'b0, 1'b0);

    // Zero-length test completes at once
    baslat0 = 1'b1;
    step();
    baslat0 = 1'b0;
    chk("len0_bitti", 32'(bitti0), 32'd1);
    chk("len0_basarili", 32'(basarili0), 32'd1);
    chk("len0_hata", 32'(hata0), 32'd0);
    chk("len0_za", 32'(za0), 32'd0);

`ifdef TEST_ZAMAN_ASIMI_EN
    no_resp = 1; mask = '0; rnd = 0; cevap_cyc = 0;
    baslat = 1'b1;
    step();
    baslat = 1'b0;
    for (k = 0; k < 500 && !bitti; k++) step();
    chk("wd_bitti", 32'(bitti), 32'd1);
    chk("wd_zaman_asimi", 32'(za), 32'd1);
    chk("wd_basarili", 32'(basarili), 32'd0);
    chk("wd_cycles_waiting", 32'(cevap_cyc), 32'd32);
    chk("wd_drops", {30'd0, gecerli, cevap_hazir}, 32'd0);
    rst = 1'b1;
    step();
    chk("wd_rst_clears", 32'(za), 32'd0);
    rst = 1'b0;
    no_resp = 0;
    step();
    run_pass(16'h0000, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_limit
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
